// File: rtl/wb_serial_master.sv
// Byte-stream to Wishbone bridge: parses 'W'/'R' commands from rx bytes, runs one
// pipelined Wishbone cycle per command and returns response bytes on the tx side.
module wb_serial_master #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i,
  output logic        busy_o,
  output logic        overrun_o,
  output logic [2:0]  dbg_state_o
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_Q = 8'h3F;
  localparam logic [7:0] RSP_E = 8'h45;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, WAIT, RESP} state_t;

  state_t          state, state_nx;
  logic [1:0]      byte_cnt;
  logic            is_write;
  logic [31:0]     adr, wdat, resp;
  logic [2:0]      resp_cnt;
  logic [TW-1:0]   tmr;
  logic            overrun;
  logic            ld_resp;
  logic [31:0]     resp_nx;
  logic [2:0]      resp_cnt_nx;
  logic            timed_out;

  // Handshakes: rx is a strobe with no backpressure; tx moves a byte on any
  // cycle with tx_valid_o & tx_ready_i; a Wishbone strobe is taken when stb & !stall.
  assign timed_out = (tmr == TW'(TIMEOUT));

  always_comb begin
    state_nx    = state;
    ld_resp     = 1'b0;
    resp_nx     = '0;
    resp_cnt_nx = '0;
    case (state)
      IDLE: begin
        if (rx_valid_i) begin
          if (rx_data_i == CMD_W || rx_data_i == CMD_R) begin
            state_nx = ADDR;
          end else begin
            state_nx    = RESP;
            ld_resp     = 1'b1;
            resp_nx     = {RSP_Q, 24'h0};
            resp_cnt_nx = 3'd1;
          end
        end
      end
      ADDR: if (rx_valid_i && byte_cnt == 2'd3) state_nx = is_write ? DATA : REQ;
      DATA: if (rx_valid_i && byte_cnt == 2'd3) state_nx = REQ;
      REQ, WAIT: begin
        // An ack in the accept cycle completes directly; completion beats timeout.
        if (wb_ack_i && (state == WAIT || !wb_stall_i)) begin
          state_nx = RESP;
          ld_resp  = 1'b1;
          if (is_write) begin
            resp_nx     = {RSP_K, 24'h0};
            resp_cnt_nx = 3'd1;
          end else begin
            resp_nx     = wb_dat_i;
            resp_cnt_nx = 3'd4;
          end
        end else if (timed_out) begin
          state_nx    = RESP;
          ld_resp     = 1'b1;
          resp_nx     = {RSP_E, 24'h0};
          resp_cnt_nx = 3'd1;
        end else if (state == REQ && !wb_stall_i) begin
          state_nx = WAIT;
        end
      end
      RESP: if (tx_ready_i && resp_cnt == 3'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      byte_cnt <= '0;
      is_write <= 1'b0;
      adr      <= '0;
      wdat     <= '0;
      resp     <= '0;
      resp_cnt <= '0;
      tmr      <= '0;
      overrun  <= 1'b0;
    end else begin
      if (state == IDLE && rx_valid_i) begin
        byte_cnt <= '0;
        is_write <= (rx_data_i == CMD_W);
      end
      if ((state == ADDR || state == DATA) && rx_valid_i) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == ADDR) adr  <= {adr[23:0], rx_data_i};
        else               wdat <= {wdat[23:0], rx_data_i};
      end
      if (state == REQ || state == WAIT) tmr <= tmr + 1'b1;
      else                               tmr <= '0;
      // Response bytes leave MSB first from the top of the shift register.
      if (ld_resp) begin
        resp     <= resp_nx;
        resp_cnt <= resp_cnt_nx;
      end else if (state == RESP && tx_ready_i) begin
        resp     <= {resp[23:0], 8'h00};
        resp_cnt <= resp_cnt - 3'd1;
      end
      if (rx_valid_i && (state == REQ || state == WAIT || state == RESP)) overrun <= 1'b1;
    end
  end

  assign wb_cyc_o    = (state == REQ) || (state == WAIT);
  assign wb_stb_o    = (state == REQ);
  assign wb_we_o     = wb_cyc_o & is_write;
  assign wb_adr_o    = adr & 32'hFFFF_FFFC;
  assign wb_dat_o    = wdat;
  assign wb_sel_o    = 4'hF;
  assign tx_valid_o  = (state == RESP);
  assign tx_data_o   = resp[31:24];
  assign busy_o      = (state != IDLE);
  assign overrun_o   = overrun;
  assign dbg_state_o = state;

endmodule

// File: tb/tb_wb_serial_master.sv
// Randomized bench for wb_serial_master: a Wishbone slave model, a tx sink with random
// ready, and a command-level reference model predicting bus cycles and response bytes.
module tb_wb_serial_master;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_stall_i = 1'b0;
  logic        busy_o, overrun_o;
  logic [2:0]  dbg_state;

  wb_serial_master #(.TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i),
    .busy_o(busy_o), .overrun_o(overrun_o), .dbg_state_o(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  // slave and sink configuration, written only by the main sequence
  int          stall_cfg = 0;
  int          ack_delay = 0;
  bit          no_ack = 1'b0;
  bit          rdy_rand = 1'b0;
  logic [31:0] rd_data = '0;
  int          late_req = 0;

  // observations, written only by the negedge slave/monitor process
  int          late_done = 0;
  int          ack_cd = -1;
  int          stall_left = 0;
  bit          prev_stb = 1'b0, prev_cyc = 1'b0, prev_txv = 1'b0, prev_acc = 1'b0;
  logic [7:0]  prev_txd = '0;
  int          cyc_len = 0, stb_len = 0;
  bit          adr_moved = 1'b0, resp_follows = 1'b0;
  logic [31:0] adr0 = '0, dat0 = '0;
  logic        we0 = 1'b0;
  int          tx_unstable = 0;
  logic [7:0]  rx_log [0:255];
  int          rx_wr = 0;
  logic [31:0] bus_adr [0:63];
  logic [31:0] bus_dat [0:63];
  logic        bus_we  [0:63];
  logic [3:0]  bus_sel [0:63];
  int          bus_wr = 0;

  always @(negedge clk) begin
    wb_ack_i = 1'b0;
    if (ack_cd == 0) begin
      wb_ack_i = !no_ack;
      ack_cd = -1;
    end else if (ack_cd > 0) begin
      ack_cd = ack_cd - 1;
    end
    if (late_req != late_done) begin
      wb_ack_i = 1'b1;
      late_done = late_req;
    end
    wb_dat_i = wb_ack_i ? rd_data : $urandom();
    wb_stall_i = 1'b0;
    if (wb_cyc_o && wb_stb_o) begin
      if (!prev_stb) stall_left = stall_cfg;
      if (stall_left > 0) begin
        wb_stall_i = 1'b1;
        stall_left = stall_left - 1;
      end else begin
        ack_cd = ack_delay;
        bus_adr[bus_wr % 64] = wb_adr_o;
        bus_dat[bus_wr % 64] = wb_dat_o;
        bus_we[bus_wr % 64]  = wb_we_o;
        bus_sel[bus_wr % 64] = wb_sel_o;
        bus_wr = bus_wr + 1;
      end
    end
    prev_stb = wb_stb_o;
    if (wb_cyc_o) begin
      if (!prev_cyc) begin
        cyc_len = 0;
        stb_len = 0;
        adr0 = wb_adr_o;
        dat0 = wb_dat_o;
        we0 = wb_we_o;
        adr_moved = 1'b0;
      end
      cyc_len = cyc_len + 1;
      if (wb_stb_o) stb_len = stb_len + 1;
      if (wb_adr_o != adr0 || wb_dat_o != dat0 || wb_we_o != we0) adr_moved = 1'b1;
    end
    if (tx_valid_o && !prev_txv) resp_follows = prev_cyc;
    if (tx_valid_o && prev_txv && !prev_acc && tx_data_o != prev_txd) tx_unstable = tx_unstable + 1;
    tx_ready_i = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    prev_acc = tx_valid_o && tx_ready_i;
    if (prev_acc) begin
      rx_log[rx_wr % 256] = tx_data_o;
      rx_wr = rx_wr + 1;
    end
    prev_cyc = wb_cyc_o;
    prev_txv = tx_valid_o;
    prev_txd = tx_data_o;
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_fail = 0;
  int          rx_rd = 0;
  int          bus_rd = 0;
  bit          ovr_exp = 1'b0;
  logic [7:0]  cmd_q[$];
  logic [7:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // driver: random command builder (0 = write, 1 = read, 2 = unknown opcode)
  task automatic make_cmd(input int kind);
    logic [7:0] b;
    cmd_q.delete();
    if (kind == 2) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'h57 || b == 8'h52);
      cmd_q.push_back(b);
    end else begin
      cmd_q.push_back(kind == 0 ? 8'h57 : 8'h52);
      for (int i = 0; i < (kind == 0 ? 8 : 4); i++) cmd_q.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  // mode 0: plain command, 1: inject a byte during WAIT, 2: reset during WAIT
  task automatic run_cmd(input int mode);
    logic [7:0]  op;
    logic [31:0] e_adr, e_dat;
    bit          e_we, is_bus;
    int          e_cyc, e_stb;
    op = cmd_q[0];
    is_bus = (op == 8'h57 || op == 8'h52);
    e_we = (op == 8'h57);
    e_adr = '0;
    e_dat = '0;
    if (is_bus) e_adr = {cmd_q[1], cmd_q[2], cmd_q[3], cmd_q[4]} & 32'hFFFF_FFFC;
    if (e_we) e_dat = {cmd_q[5], cmd_q[6], cmd_q[7], cmd_q[8]};
    exp_q.delete();
    if (!is_bus) exp_q.push_back(8'h3F);
    else if (no_ack) exp_q.push_back(8'h45);
    else if (e_we) exp_q.push_back(8'h4B);
    else for (int i = 3; i >= 0; i--) exp_q.push_back(rd_data[8*i +: 8]);
    e_cyc = no_ack ? TMO + 1 : stall_cfg + ack_delay + 2;
    e_stb = stall_cfg + 1;

    foreach (cmd_q[i]) begin
      if (i > 0) repeat ($urandom_range(0, 2)) tick();
      rx_data_i = cmd_q[i];
      rx_valid_i = 1'b1;
      tick();
      rx_valid_i = 1'b0;
      rx_data_i = 8'($urandom_range(0, 255));
    end
    if (is_bus) begin
      check("lat_cyc", 32'(wb_cyc_o), 1);
      check("lat_stb", 32'(wb_stb_o), 1);
      check("lat_adr", wb_adr_o, e_adr);
      check("lat_we", 32'(wb_we_o), 32'(e_we));
      if (e_we) check("lat_dat", wb_dat_o, e_dat);
    end

    if (mode != 0) begin
      for (int t = 0; t < 40 && !(wb_cyc_o && !wb_stb_o); t++) tick();
      check("reach_wait", 32'(wb_cyc_o && !wb_stb_o), 1);
    end
    if (mode == 1) begin
      rx_data_i = 8'h52;
      rx_valid_i = 1'b1;
      tick();
      rx_valid_i = 1'b0;
      ovr_exp = 1'b1;
      check("ovr_set", 32'(overrun_o), 1);
    end
    if (mode == 2) begin
      repeat (2) tick();
      check("ovr_before_rst", 32'(overrun_o), 32'(ovr_exp));
      #2 rst_i = 1'b0;
      #1;
      check("rst_cyc", 32'(wb_cyc_o), 0);
      check("rst_stb", 32'(wb_stb_o), 0);
      check("rst_txv", 32'(tx_valid_o), 0);
      check("rst_ovr", 32'(overrun_o), 0);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_adr", wb_adr_o, 0);
      repeat (3) tick();
      rst_i = 1'b1;
      ovr_exp = 1'b0;
      exp_q.delete();
      repeat (30) tick();
      check("rst_noresp", rx_wr - rx_rd, 0);
      rx_rd = rx_wr;
      bus_rd = bus_wr;
      return;
    end

    for (int t = 0; t < 300 && (rx_wr - rx_rd) < exp_q.size(); t++) tick();
    check("resp_count", rx_wr - rx_rd, exp_q.size());
    while (exp_q.size() > 0 && rx_rd < rx_wr) begin
      check("resp_byte", 32'(rx_log[rx_rd % 256]), 32'(exp_q.pop_front()));
      rx_rd++;
    end
    exp_q.delete();
    tick();
    check("busy_fall", 32'(busy_o), 0);
    repeat (3) tick();
    check("extra_tx", rx_wr - rx_rd, 0);
    rx_rd = rx_wr;

    check("bus_cnt", bus_wr - bus_rd, is_bus ? 1 : 0);
    if (is_bus && bus_wr != bus_rd) begin
      check("bus_adr", bus_adr[bus_rd % 64], e_adr);
      check("bus_we", 32'(bus_we[bus_rd % 64]), 32'(e_we));
      check("bus_sel", 32'(bus_sel[bus_rd % 64]), 32'hF);
      if (e_we) check("bus_dat", bus_dat[bus_rd % 64], e_dat);
      check("cyc_len", cyc_len, e_cyc);
      check("stb_len", stb_len, e_stb);
      check("adr_stable", 32'(adr_moved), 0);
      check("resp_follows", 32'(resp_follows), 1);
    end
    bus_rd = bus_wr;
    check("ovr_state", 32'(overrun_o), 32'(ovr_exp));
  endtask

  initial begin
    rst_i = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i = '0;
    #2 rst_i = 1'b0;
    #1;
    check("reset_cyc", 32'(wb_cyc_o), 0);
    check("reset_stb", 32'(wb_stb_o), 0);
    check("reset_we", 32'(wb_we_o), 0);
    check("reset_txv", 32'(tx_valid_o), 0);
    check("reset_busy", 32'(busy_o), 0);
    check("reset_ovr", 32'(overrun_o), 0);
    check("reset_txd", 32'(tx_data_o), 0);
    check("reset_adr", wb_adr_o, 0);
    check("reset_dat", wb_dat_o, 0);
    check("reset_sel", 32'(wb_sel_o), 32'hF);
    repeat (2) tick();
    rst_i = 1'b1;
    repeat (2) tick();
    rx_rd = rx_wr;
    bus_rd = bus_wr;

    // directed write, zero-wait slave
    cmd_q = '{8'h57, 8'h00, 8'h00, 8'h40, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_cmd(0);

    // directed read with random tx_ready
    rdy_rand = 1'b1;
    rd_data = 32'h1234_5678;
    cmd_q = '{8'h52, 8'h00, 8'h00, 8'h40, 8'h10};
    run_cmd(0);

    // stalled write then stalled read
    stall_cfg = 5;
    make_cmd(0);
    run_cmd(0);
    rd_data = $urandom();
    make_cmd(1);
    run_cmd(0);
    stall_cfg = 0;

    // timeouts, each followed by a late ack that must be ignored
    no_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      make_cmd(k);
      run_cmd(0);
      late_req++;
      repeat (10) tick();
      check("late_ack_noresp", rx_wr - rx_rd, 0);
      check("late_ack_busy", 32'(busy_o), 0);
    end
    no_ack = 1'b0;

    // unknown opcode
    cmd_q = '{8'h41};
    run_cmd(0);

    // overrun during WAIT, then a normal read
    ack_delay = 8;
    rd_data = $urandom();
    make_cmd(1);
    run_cmd(1);
    ack_delay = 0;
    rd_data = $urandom();
    make_cmd(1);
    run_cmd(0);

    // randomized mix
    for (int n = 0; n < 12; n++) begin
      stall_cfg = $urandom_range(0, 3);
      ack_delay = $urandom_range(0, 3);
      no_ack = ($urandom_range(0, 5) == 0);
      rdy_rand = ($urandom_range(0, 1) == 1);
      rd_data = $urandom();
      make_cmd($urandom_range(0, 2));
      run_cmd(0);
    end
    stall_cfg = 0;
    no_ack = 1'b0;

    // asynchronous reset in WAIT, then a fresh write
    ack_delay = 10;
    rd_data = $urandom();
    make_cmd(1);
    run_cmd(2);
    ack_delay = 0;
    make_cmd(0);
    run_cmd(0);

    check("tx_hold", tx_unstable, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_serial_master.md
# wb_serial_master

Byte-stream-to-Wishbone bus initiator, used as a debug and loader port. It sits between the UART byte interface and an MMU master port alongside the CPU data bus. The host can then read or write any 32-bit word the MMU decodes, such as RAM, ROM shadow, IO or the framebuffer. Each command is parsed from received bytes, issued as a single pipelined Wishbone cycle, and answered with response bytes.

## Interface
- `TIMEOUT`, 1024: number of `clk_i` cycles to wait for `wb_ack_i` before abandoning a bus cycle; must be ≥2.
- `clk_i`  in  1  system clock; all logic is on its rising edge.
- `rst_i`  in  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is sampled on `clk_i`.
- `rx_data_i`  in  8  received byte.
- `rx_valid_i`  in  1  one-cycle strobe: `rx_data_i` is valid. There is no backpressure on this input.
- `tx_data_o`  out  8  response byte.
- `tx_valid_o`  out  1  response byte is valid; held until `tx_ready_i`.
- `tx_ready_i`  in  1  transmitter accepts `tx_data_o` in any cycle where `tx_valid_o & tx_ready_i`.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  Wishbone cycle, strobe and write-enable.
- `wb_adr_o`  out  32  byte address; bits [1:0] are driven as 0.
- `wb_dat_o`  out  32  write data.
- `wb_sel_o`  out  4  byte selects; always 4'hF.
- `wb_dat_i`  in  32  read data.
- `wb_ack_i`, `wb_stall_i`  in  1 each  slave acknowledge and stall.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `overrun_o`  out  1  sticky: a received byte was dropped. Cleared only by reset.

## Operation
Command format, multi-byte fields big-endian:
- Write: `0x57 'W'`, then A3 A2 A1 A0, then D3 D2 D1 D0. Response is `0x4B 'K'`.
- Read: `0x52 'R'`, then A3 A2 A1 A0. Response is D3 D2 D1 D0.
- Any other command byte gets the single response `0x3F '?'`.
- A bus timeout in either command gets the single response `0x45 'E'`.

State machine:
- IDLE: on `rx_valid_i`, decode the command byte.
  - 'W' or 'R': go to ADDR with byte counter = 0.
  - Anything else: load '?' and go to RESP.
- ADDR: shift each received byte into the address register, MSB first. After the 4th byte, 'W' goes to DATA and 'R' goes to REQ.
- DATA: shift 4 bytes into the write-data register, then go to REQ.
- REQ: drive `cyc`=1, `stb`=1, and `we` = 1 for write, 0 for read.
  - When `wb_stall_i`=0, the strobe is accepted. Next cycle, `stb`=0 and go to WAIT.
  - `wb_ack_i` in the accept cycle itself is also honoured: go straight to completion.
- WAIT: `cyc`=1. On `wb_ack_i`:
  - Latch `wb_dat_i` on a read.
  - Drop `cyc` next cycle.
  - Load the response ('K', or 4 read bytes) and go to RESP.
- Timeout: a counter starts at REQ entry and counts both REQ and WAIT cycles. When it reaches `TIMEOUT`:
  - `cyc` and `stb` are dropped on the next cycle.
  - Response 'E' is loaded and the state goes to RESP.
  - A late `wb_ack_i` after the abort is ignored.
- RESP: present the response bytes in order, with `tx_valid_o` held. Advance on each accepted byte. After the last accept, return to IDLE.

Boundary rules:
- An `rx_valid_i` arriving in REQ, WAIT or RESP: the byte is dropped and `overrun_o` is set. The byte is not parsed later.
- The address register wraps naturally; there is no range check (the MMU decodes the address).
- Reset mid-command or mid-cycle: all outputs drop immediately, asynchronously, with no completion and no response.

Reset values:
- `tx_valid_o`, `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `busy_o`, `overrun_o` = 0.
- `tx_data_o`, `wb_adr_o`, `wb_dat_o` = 0.
- `wb_sel_o` = 4'hF.
- State = IDLE.

## Timing
- The cycle after the last command byte's `rx_valid_i`, `wb_cyc_o`, `wb_stb_o` and the final `wb_adr_o`/`wb_dat_o`/`wb_we_o` are all valid.
- `wb_adr_o`, `wb_dat_o` and `wb_we_o` stay stable from strobe assertion until `cyc` drops.
- With zero-wait-state slaves (no stall, ack one cycle after strobe), `cyc` is high for exactly 2 cycles.
- The cycle after ack: `cyc`=0 and `tx_valid_o`=1 with the first response byte.
- A new byte may be presented the cycle after each `tx_valid_o & tx_ready_i`.
- `busy_o` falls in the cycle after the last response byte is accepted.
- Timeout: 'E' appears `TIMEOUT`+1 cycles after strobe assertion.
- Maximum command-to-bus latency is 1 cycle; there are no combinational paths from rx to wb.

## Test plan
- Write: send 57 00 00 40 10 DE AD BE EF with a zero-wait slave.
  - One bus cycle with adr=0x00004010, dat=0xDEADBEEF, we=1, sel=F.
  - Response 'K' the cycle after ack.
- Read: send 52 00 00 40 10 with the slave returning 0x12345678.
  - One bus cycle with we=0.
  - Response 12 34 56 78, in order, with `tx_ready_i` toggled randomly.
- Stall: slave holds `wb_stall_i` for 5 cycles then acks.
  - `stb` stays asserted for exactly 6 cycles and address stays stable.
  - Correct response follows.
- Timeout: `TIMEOUT`=16, slave never acks, on both W and R.
  - `cyc` drops 17 cycles after strobe and the response is 'E'.
  - A late ack after that causes no second response.
- Bad command and overrun:
  - Byte 0x41 gives response '?'.
  - A byte sent during WAIT sets `overrun_o` and is not parsed.
  - The next valid 'R' command still works.
- Reset: assert `rst_i`=0 mid-WAIT, asynchronously.
  - `cyc`, `stb` and `tx_valid_o` go low immediately and `overrun_o` clears.
  - After release, a fresh 'W' completes normally.
